// File: rtl/seven_seg_scanner_pkg.sv
// Shared display definitions for the multiplexed seven-segment scanner.
// Holds the active-low segment table, the blank pattern and slot states.
package seven_seg_scanner_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry i is the G..A pattern for hex digit i (listed F down to 0).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110,
        7'b0000110,
        7'b0100001,
        7'b1000110,
        7'b0000011,
        7'b0001000,
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

endpackage

// File: rtl/seven_seg_scanner_dec.sv
// Combinational hex to active-low seven-segment decoder.
// Decimal point passes through inverted for common-anode parts.
module seven_seg_scanner_dec
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       dp_i,
    output logic [6:0] seg_n_o,
    output logic       dp_n_o
);

    assign seg_n_o = SEG_LUT[hex_i];
    assign dp_n_o  = ~dp_i;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display scanner with frame-aligned
// updates and a per-slot blanking interval against ghosting.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    value_valid,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    update_ack,
    output logic                    frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [VW-1:0]         pend_val_q, shad_val_q;
    logic [NUM_DIGITS-1:0] pend_dp_q, shad_dp_q;
    logic                  pend_flag_q;
    slot_state_e           state_q, state_d;

    logic [6:0]            seg_n_q;
    logic                  dp_n_q;
    logic [NUM_DIGITS-1:0] an_n_q;
    logic                  ack_q;
    logic                  fs_q;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [3:0]            cur_nib;
    logic [6:0]            dec_seg_n;
    logic                  dec_dp_unused;

    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_end && (digit_q == DIG_LAST);

    assign cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    assign digit_d = frame_wrap ? '0
                   : slot_end ? digit_q + 1'b1
                   : digit_q;

    assign state_d = (cnt_q < CNT_BLANK) ? ST_BLANK : ST_DRIVE;

    assign cur_nib = shad_val_q[{digit_q, 2'b00} +: 4];

    seven_seg_scanner_dec u_dec (
        .hex_i   (cur_nib),
        .dp_i    (1'b0),
        .seg_n_o (dec_seg_n),
        .dp_n_o  (dec_dp_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            digit_q     <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            shad_val_q  <= '0;
            shad_dp_q   <= '0;
            state_q     <= ST_BLANK;
            seg_n_q     <= SEG_OFF;
            dp_n_q      <= 1'b1;
            an_n_q      <= '1;
            ack_q       <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            state_q <= state_d;

            // A strobe on the wrap edge re-arms the flag for next frame.
            if (value_valid) begin
                pend_val_q  <= value_in;
                pend_dp_q   <= dp_in;
                pend_flag_q <= 1'b1;
            end else if (frame_wrap) begin
                pend_flag_q <= 1'b0;
            end

            if (frame_wrap && pend_flag_q) begin
                shad_val_q <= pend_val_q;
                shad_dp_q  <= pend_dp_q;
            end

            ack_q <= frame_wrap && pend_flag_q;
            fs_q  <= frame_wrap;

            unique case (state_d)
                ST_DRIVE: begin
                    if (digit_en[digit_q]) begin
                        seg_n_q <= dec_seg_n;
                        dp_n_q  <= ~shad_dp_q[digit_q];
                        an_n_q  <= ~(AN_ONE << digit_q);
                    end else begin
                        seg_n_q <= SEG_OFF;
                        dp_n_q  <= 1'b1;
                        an_n_q  <= '1;
                    end
                end
                default: begin
                    seg_n_q <= SEG_OFF;
                    dp_n_q  <= 1'b1;
                    an_n_q  <= '1;
                end
            endcase
        end
    end

    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign an_n        = an_n_q;
    assign update_ack  = ack_q;
    assign frame_start = fs_q;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexes one hex-to-segment decoder across NUM_DIGITS common-anode digits on the board display. Debug and status nibbles from the HDR pipeline are shown through this block.
- A value is loaded into a pending register and becomes visible only at a frame boundary, so the display never tears.
- A blanking interval at the start of each digit slot suppresses ghosting.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ BLANK_CYCLES+2).
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value_in  in  4*NUM_DIGITS  nibble i drives digit i (digit 0 = bits [3:0])
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- value_valid  in  1  one-cycle strobe; captures value_in and dp_in into pending
- digit_en  in  NUM_DIGITS  live mask; 0 = digit dark in its slot
- seg_n  out  7  segments active-low, [0]=A … [6]=G
- dp_n  out  1  decimal point, active-low
- an_n  out  NUM_DIGITS  digit anodes, active-low
- update_ack  out  1  one-cycle pulse when pending is transferred to shadow
- frame_start  out  1  one-cycle pulse when the digit index wraps to 0

Behaviour:
- Reset (async assert, sync release):
  - seg_n=7'h7F, dp_n=1, an_n=all 1, update_ack=0, frame_start=0.
  - cnt=0, digit=0, pending and shadow = 0, pending_flag=0.
- Counters:
  - cnt runs 0..REFRESH_DIV-1.
  - On cnt wrap, digit increments 0..NUM_DIGITS-1, then wraps to 0.
  - Frame length = NUM_DIGITS*REFRESH_DIV cycles.
- Per-slot FSM, two states: BLANK (cnt<BLANK_CYCLES) and DRIVE (otherwise).
  - BLANK: all anodes off, seg_n=7'h7F, dp_n=1.
  - DRIVE, digit_en[digit]=1: an_n[digit]=0 and all other anodes 1. seg_n = decoder(shadow nibble[digit]); dp_n = ~shadow_dp[digit].
  - DRIVE, digit_en[digit]=0: same as BLANK. The slot time is still consumed, so brightness stays constant.
- Output timing: all outputs are registered, with 1-cycle latency from (cnt, digit) state. The first lit cycle of a slot is the cycle after cnt reaches BLANK_CYCLES.
- Only one anode is ever low; an_n never has two zeros in the same cycle.
- Decoder mapping (seg_n[6:0] = G..A):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110
- Update path:
  - value_valid captures {value_in, dp_in} into pending and sets pending_flag.
  - Back-to-back strobes overwrite pending; last one wins.
  - On the frame-wrap edge (digit=NUM_DIGITS-1, cnt=REFRESH_DIV-1): if pending_flag, shadow<=pending, flag cleared, update_ack pulses the next cycle.
  - If value_valid coincides with the wrap edge, the old pending is transferred and the new value becomes pending, shown next frame.
- frame_start is asserted in the cycle after every wrap edge.
- Reset mid-frame: outputs blank immediately (async); the scan restarts from digit 0, cnt 0; pending data is lost.
- digit_en changes take effect in the next output cycle, with no waiting for the frame.

Decomposition:
- Shared display package holds:
  - the 16-entry active-low segment constant table;
  - SEG_OFF=7'h7F;
  - the BLANK/DRIVE state encoding.
- Sub-module: the existing combinational seven_seg hex decoder is instantiated once, fed by the muxed shadow nibble. Its DP output is ignored; the scanner drives dp_n itself.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset → seg_n=7F, an_n=1111, dp_n=1. After release, the first frame shows shadow=0: an_n cycles 1110→1101→1011→0111, seg_n=1000000 in each lit window of 6 cycles, 2 dark cycles between.
- value_in=16'h8A31, dp_in=4'b0100, value_valid one cycle mid-frame → old digits held until wrap. Then update_ack pulses once. Next frame: digit0=1111001, digit1=0110000, digit2=0001000 with dp_n=0, digit3=0000000.
- value_valid exactly on the wrap edge with 16'h1234 while pending 16'hFFFF → next frame shows FFFF, the following frame 1234. Two update_acks, one frame apart.
- digit_en=4'b0101 → an_n never drives digits 1 or 3 low. The slot length stays 8 cycles and frame_start spacing stays 32 cycles.
- rst_n asserted in digit 2's DRIVE window → all outputs blank in the same cycle without waiting for clk. After release the scan resumes at digit 0 and shadow=0.
- Random run over 10k cycles → assertion: at most one zero in an_n, and an_n=1111 throughout every BLANK window.
